// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
package fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; flush overrides any same-cycle push or pop.
module fetch_fifo #(
    parameter int  W     = 32,
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);
    localparam int            AW   = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;
    always_comb begin
        do_pop  = pop & (cnt_q != '0);
        do_push = push & ((cnt_q != FULL) | do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = wdata;
        rd_d  = flush ? '0 : do_pop ? (rd_q == LAST ? '0 : rd_q + AW'(1)) : rd_q;
        wr_d  = flush ? '0 : do_push ? (wr_q == LAST ? '0 : wr_q + AW'(1)) : wr_q;
        cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
    assign rdata = mem_q[rd_q];
    assign count = cnt_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage - PC, credit-limited imem requests, response buffer to decode.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects on fetch_fault.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instrCode,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);
    logic [31:0]   pc_q, pc_d, tag, redirect_tgt;
    logic [CW-1:0] kill_cnt_q, kill_cnt_d, out_cnt, fifo_count;
    logic          fault, req_fire, rsp_ok, keep;
    fetch_entry_t  head;
    assign redirect_tgt = redirect_pc & ~32'h3;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d;
    assign fault_d     = fault_q | (redirect_valid & (redirect_pc[1:0] != 2'b00));
    assign fault       = fault_q;
    assign fetch_fault = fault_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fault_q <= 1'b0;
        else          fault_q <= fault_d;
    end
`else
    assign fault = 1'b0;
`endif
    // Outstanding requests plus buffered words never exceed DEPTH, so a response always finds a slot.
    always_comb begin
        imem_req_valid = reset_n & ~redirect_valid & ~fault & (({1'b0, out_cnt} + {1'b0, fifo_count}) < CREDITS);
        req_fire       = imem_req_valid & imem_req_ready;
        rsp_ok         = imem_rsp_valid & (out_cnt != '0);
        keep           = rsp_ok & (kill_cnt_q == '0);
        pc_d           = redirect_valid ? redirect_tgt : req_fire ? pc_q + 32'd4 : pc_q;
        kill_cnt_d     = redirect_valid ? out_cnt - CW'(rsp_ok) : kill_cnt_q - CW'(rsp_ok & ~keep);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            kill_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end
    // Tags are never flushed: killed responses still have to pop their tag.
    fetch_fifo #(.W(32), .DEPTH(DEPTH)) u_tag_q (
        .clk    (clk),
        .reset_n(reset_n),
        .flush  (1'b0),
        .push   (req_fire),
        .wdata  (pc_q),
        .pop    (rsp_ok),
        .rdata  (tag),
        .count  (out_cnt)
    );
    fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_buf (
        .clk    (clk),
        .reset_n(reset_n),
        .flush  (redirect_valid),
        .push   (keep),
        .wdata  ({tag, imem_rsp_data}),
        .pop    (instr_ready),
        .rdata  (head),
        .count  (fifo_count)
    );
    assign imem_addr   = pc_q;
    assign instr_valid = fifo_count != '0;
    assign instr_pc    = head.pc;
    assign instrCode   = head.instr;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench with a fixed-latency in-order memory model and a decode monitor.
module tb_instr_fetch_unit;
    import fetch_pkg::*;
    logic        clk = 1'b0, reset_n = 1'b1;
    logic        imem_req_ready = 1'b1, imem_rsp_valid = 1'b0, instr_ready = 1'b1, redirect_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0, redirect_pc = '0;
    logic        req_valid, instr_valid, req_valid2, instr_valid2;
    logic [31:0] imem_addr, instrCode, instr_pc, addr2, code2, pc2;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_fault, fault2;
`endif
    int          errors = 0, checks = 0, cyc = 0, lat = 1, reqs = 0, pops = 0;
    logic [31:0] exp_pc = 32'h100;
    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;
    mreq_t mq[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req_valid(req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instrCode     (instrCode),
        .instr_pc      (instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_fault   (fetch_fault)
`endif
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut2 (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req_valid(req_valid2),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (addr2),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid2),
        .instr_ready   (instr_ready),
        .instrCode     (code2),
        .instr_pc      (pc2),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_fault   (fault2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        #1;
        if (req_valid && imem_req_ready) begin
            mq.push_back('{cyc + lat, imem_addr});
            reqs++;
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
            check("dec_pc", instr_pc, exp_pc);
            check("dec_code", instrCode, NOP_INSTR + exp_pc);
            exp_pc += 32'd4;
            pops++;
        end
        @(posedge clk);
        #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = NOP_INSTR + mq[0].addr;
            void'(mq.pop_front());
        end
        #1;
        if (imem_rsp_valid) check("rsp_outstanding", 32'(dut.out_cnt != '0), 32'd1);
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        imem_rsp_valid = 1'b0;
        mq.delete();
        #1;
        check("rst_async_req_valid", 32'(req_valid), 32'd0);
        check("rst_async_instr_valid", 32'(instr_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_instr_code", instrCode, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_pc", imem_addr, 32'h100);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("rst_fault", 32'(fetch_fault), 32'd0);
`endif
        reset_n = 1'b1;
        cyc     = 0;
        reqs    = 0;
        pops    = 0;
        exp_pc  = 32'h100;
        #1;
        check("first_req_valid", 32'(req_valid), 32'd1);
        check("first_req_addr", imem_addr, 32'h100);
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        // free-run, L=1
        do_reset();
        check("wrap_addr0", addr2, 32'hFFFF_FFFC);
        check("wrap_req_valid", 32'(req_valid2), 32'd1);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("wrap_fault", 32'(fault2), 32'd0);
`endif
        check("c0_valid", 32'(instr_valid), 32'd0);
        step();
        check("wrap_addr1", addr2, 32'h0000_0000);
        check("c1_valid", 32'(instr_valid), 32'd0);
        step();
        check("c2_valid", 32'(instr_valid), 32'd1);
        check("c2_pc", instr_pc, 32'h100);
        check("wrap_pc", pc2, 32'hFFFF_FFFC);
        check("wrap_valid", 32'(instr_valid2), 32'd1);
        check("wrap_code", code2, NOP_INSTR + 32'h100);
        repeat (28) step();
        check("free_pops", 32'(pops >= 15), 32'd1);
        // back-pressure
        instr_ready = 1'b0;
        do_reset();
        repeat (10) step();
        check("bp_reqs", reqs, 32'd2);
        check("bp_req_valid", 32'(req_valid), 32'd0);
        check("bp_valid", 32'(instr_valid), 32'd1);
        check("bp_pc", instr_pc, 32'h100);
        instr_ready = 1'b1;
        repeat (12) step();
        check("bp_pops", 32'(pops >= 6), 32'd1);
        // redirect with two outstanding, L=3
        lat = 3;
        do_reset();
        step();
        step();
        check("rd_out", 32'(dut.out_cnt), 32'd2);
        exp_pc = 32'h200;
        redirect(32'h200);
        check("rd_addr", imem_addr, 32'h200);
        check("rd_kill", 32'(dut.kill_cnt_q), 32'd2);
        for (int i = 0; i < 12 && !instr_valid; i++) step();
        check("rd_valid", 32'(instr_valid), 32'd1);
        check("rd_first_pc", instr_pc, 32'h200);
        repeat (12) step();
        check("rd_pops", 32'(pops >= 3), 32'd1);
        // redirect coinciding with a response and a decode pop
        lat = 1;
        do_reset();
        step();
        step();
        check("co_valid_pre", 32'(instr_valid), 32'd1);
        check("co_out_pre", 32'(dut.out_cnt), 32'd1);
        exp_pc = 32'h300;
        redirect(32'h300);
        check("co_valid", 32'(instr_valid), 32'd0);
        check("co_kill", 32'(dut.kill_cnt_q), 32'd0);
        check("co_addr", imem_addr, 32'h300);
        check("co_req", 32'(req_valid), 32'd1);
        repeat (10) step();
        check("co_pops", 32'(pops >= 3), 32'd1);
        // misaligned redirect
        do_reset();
        step();
        step();
`ifdef FETCH_MISALIGN_CHECK_EN
        redirect(32'h202);
        reqs = 0;
        check("mis_fault", 32'(fetch_fault), 32'd1);
        check("mis_req", 32'(req_valid), 32'd0);
        repeat (8) step();
        check("mis_reqs", reqs, 32'd0);
        check("mis_valid", 32'(instr_valid), 32'd0);
        check("mis_fault_hold", 32'(fetch_fault), 32'd1);
`else
        exp_pc = 32'h200;
        redirect(32'h202);
        check("mis_addr", imem_addr, 32'h200);
        check("mis_req", 32'(req_valid), 32'd1);
        repeat (10) step();
        check("mis_pops", 32'(pops >= 3), 32'd1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
